// File: rtl/fetch_stage.sv
// Instruction fetch stage: PC, one-deep in-flight tracking for a synchronous imem,
// and a 2-entry {instr, pc} queue to decode. Optional counter under FETCH_PERF_CNT_EN.
module fetch_stage #(
  parameter int              PC_W     = 8,
  parameter int              INSTR_W  = 32,
  parameter logic [PC_W-1:0] RESET_PC = {PC_W{1'b0}}
) (
  input  logic               clk,
  input  logic               rst,
  output logic               imem_req,
  output logic [PC_W-1:0]    imem_addr,
  input  logic [INSTR_W-1:0] imem_rdata,
  input  logic               redirect_valid,
  input  logic [PC_W-1:0]    redirect_pc,
  output logic               id_valid,
  input  logic               id_ready,
  output logic [INSTR_W-1:0] id_instr,
  output logic [PC_W-1:0]    id_pc
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0]        perf_fetched
`endif
);

  localparam logic [PC_W-1:0] PC_ONE = {{(PC_W-1){1'b0}}, 1'b1};

  logic [PC_W-1:0]    pc_r;
  logic [PC_W-1:0]    infl_pc_r;
  logic               inflight_r;
  logic [1:0]         count_r;
  logic [INSTR_W-1:0] instr0_r;
  logic [INSTR_W-1:0] instr1_r;
  logic [PC_W-1:0]    pc0_r;
  logic [PC_W-1:0]    pc1_r;

  logic               pop_s;
  logic               push_s;
  logic               req_s;
  logic [2:0]         occ_s;

  // Handshake and request decision; occupancy counts queued plus in-flight entries.
  always_comb begin
    pop_s  = (count_r != 2'd0) && id_ready;
    push_s = inflight_r && !redirect_valid;
    occ_s  = {1'b0, count_r} + {2'b00, inflight_r} - {2'b00, pop_s};
    req_s  = !rst && !redirect_valid && (occ_s < 3'd2);
  end

  assign imem_req  = req_s;
  assign imem_addr = pc_r;
  assign id_valid  = (count_r != 2'd0);
  assign id_instr  = instr0_r;
  assign id_pc     = pc0_r;

  // Program counter and in-flight request tracking.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_r       <= RESET_PC;
      infl_pc_r  <= {PC_W{1'b0}};
      inflight_r <= 1'b0;
    end else if (redirect_valid) begin
      pc_r       <= redirect_pc;
      inflight_r <= 1'b0;
    end else begin
      inflight_r <= req_s;
      if (req_s) begin
        pc_r      <= pc_r + PC_ONE;
        infl_pc_r <= pc_r;
      end else begin
        pc_r      <= pc_r;
        infl_pc_r <= infl_pc_r;
      end
    end
  end

  // Two-entry shift queue; slot 0 is always the head so outputs come straight from flops.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_r  <= 2'd0;
      instr0_r <= {INSTR_W{1'b0}};
      instr1_r <= {INSTR_W{1'b0}};
      pc0_r    <= {PC_W{1'b0}};
      pc1_r    <= {PC_W{1'b0}};
    end else if (redirect_valid) begin
      count_r <= 2'd0;
    end else begin
      case ({push_s, pop_s})
        2'b10: begin
          count_r <= count_r + 2'd1;
          if (count_r == 2'd0) begin
            instr0_r <= imem_rdata;
            pc0_r    <= infl_pc_r;
          end else begin
            instr1_r <= imem_rdata;
            pc1_r    <= infl_pc_r;
          end
        end
        2'b01: begin
          count_r  <= count_r - 2'd1;
          instr0_r <= instr1_r;
          pc0_r    <= pc1_r;
        end
        2'b11: begin
          if (count_r == 2'd1) begin
            instr0_r <= imem_rdata;
            pc0_r    <= infl_pc_r;
          end else begin
            instr0_r <= instr1_r;
            pc0_r    <= pc1_r;
            instr1_r <= imem_rdata;
            pc1_r    <= infl_pc_r;
          end
        end
        default: begin
          count_r <= count_r;
        end
      endcase
    end
  end

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] perf_cnt_r;

  // Completed decode transfers, including a pop in a redirect cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_cnt_r <= 32'd0;
    end else if (pop_s) begin
      perf_cnt_r <= perf_cnt_r + 32'd1;
    end else begin
      perf_cnt_r <= perf_cnt_r;
    end
  end

  assign perf_fetched = perf_cnt_r;
`endif

endmodule
